// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter and sequencer for the single-ported unified memory.
// Optional starvation guard for fetch enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    // Fetch requester
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    // Data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_signed,
    input  logic [1:0]  d_size,
    input  logic [7:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    // Memory command bus
    output logic        mem_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_signed,
    output logic [1:0]  mem_size,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    // Statistics
    output logic [15:0] if_stall_cnt
);

    localparam logic [1:0] SizeIllegal = 2'b11;

    if ((MAX_DATA_BURST < 1) || (MAX_DATA_BURST > 15)) begin : gen_bad_burst
        $error("MAX_DATA_BURST must be in 1..15");
    end

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StData
    } state_e;

    state_e      state_q, state_d;

    logic        sel_q, sel_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        signed_q, signed_d;
    logic [1:0]  size_q, size_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        if_valid_q, if_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_valid_q, d_valid_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic [15:0] stall_q, stall_d;

    logic        starve_force;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] BurstLimit = 4'(MAX_DATA_BURST);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Counts data grants that overtook a waiting fetch.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (d_gnt) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_force = (starve_cnt_q == BurstLimit);
`else
    assign starve_force = 1'b0;
`endif

    // Grants: purely a function of requests, guard counter and reset.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (d_req && !(if_req && starve_force)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Next command placed on the memory bus.
    always_comb begin
        state_d  = StIdle;
        sel_d    = 1'b0;
        read_d   = 1'b0;
        write_d  = 1'b0;
        signed_d = 1'b0;
        size_d   = 2'b00;
        addr_d   = 8'h00;
        wdata_d  = 32'h0;
        if (if_gnt) begin
            state_d = StFetch;
            sel_d   = 1'b1;
            addr_d  = if_addr;
        end else if (d_gnt) begin
            state_d  = StData;
            signed_d = d_signed;
            size_d   = d_size;
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            // Illegal sizes are accepted but never strobe the memory.
            if (d_size != SizeIllegal) begin
                read_d  = ~d_we;
                write_d = d_we;
            end
        end
    end

    // Completion of the access currently on the bus.
    always_comb begin
        if_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        d_valid_d  = 1'b0;
        d_err_d    = 1'b0;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            StFetch: begin
                if_valid_d = 1'b1;
                if_rdata_d = mem_rdata;
            end
            StData: begin
                d_valid_d = 1'b1;
                if (size_q == SizeIllegal) begin
                    d_err_d   = 1'b1;
                    d_rdata_d = 32'h0;
                end else if (read_q) begin
                    d_rdata_d = mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (if_req && !if_gnt && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 8'h00;
            wdata_q    <= 32'h0;
            if_valid_q <= 1'b0;
            if_rdata_q <= 32'h0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= 32'h0;
            stall_q    <= 16'h0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            read_q     <= read_d;
            write_q    <= write_d;
            signed_q   <= signed_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_valid_q <= if_valid_d;
            if_rdata_q <= if_rdata_d;
            d_valid_q  <= d_valid_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
            stall_q    <= stall_d;
        end
    end

    assign mem_sel      = sel_q;
    assign mem_read     = read_q;
    assign mem_write    = write_q;
    assign mem_signed   = signed_q;
    assign mem_size     = size_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign if_valid     = if_valid_q;
    assign if_rdata     = if_rdata_q;
    assign d_valid      = d_valid_q;
    assign d_err        = d_err_q;
    assign d_rdata      = d_rdata_q;
    assign if_stall_cnt = stall_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single-ported unified instruction/data memory. Arbitrates each cycle between the fetch requester (IF stage) and the data requester (MEM stage), then drives the memory phase select, read/write strobes, access size and address for the winner. The memory read data is registered and returned to the owning requester with a one-cycle valid pulse. Sits between the pipeline front/back ends and the `memory` block; the fetch stall counter feeds the hazard unit's statistics.

## Interface
- MAX_DATA_BURST, 4: consecutive contended data grants allowed before fetch is forced (1..15).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  8  fetch byte address.
- if_gnt  out  1  combinational; fetch accepted at this edge if if_req=1.
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  registered fetch word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_signed  in  1  sign-extend the load.
- d_size  in  2  00 word, 01 half, 10 byte, 11 illegal.
- d_addr  in  8  data byte address (memory applies the data offset).
- d_wdata  in  32  store data.
- d_gnt  out  1  combinational; data accepted at this edge if d_req=1.
- d_valid  out  1  one-cycle pulse; load data or store acknowledge.
- d_err  out  1  qualifies d_valid; illegal size.
- d_rdata  out  32  registered load data.
- mem_sel  out  1  memory phase select: 1 = fetch, 0 = data.
- mem_read, mem_write  out  1 each  data strobes.
- mem_signed  out  1; mem_size  out  2; mem_addr  out  8; mem_wdata  out  32.
- mem_rdata  in  32  memory read data.
- if_stall_cnt  out  16  saturating count of cycles with if_req=1 and if_gnt=0.

## Operation
- Bus states: IDLE, FETCH, DATA. The state holds the command currently driven on the mem_* outputs.
- Acceptance edge: any edge with req && gnt. At most one gnt is high. If any request is present, exactly one gnt is high, giving one access per cycle.
- Priority: data wins over fetch, except that the starvation guard forces fetch (see Configuration).
- Accepting fetch sets next state FETCH with mem_sel=1, mem_addr=if_addr and both strobes 0.
- Accepting data sets next state DATA with mem_sel=0, mem_read=~d_we, mem_write=d_we, and size, signed, addr and wdata copied.
- An illegal d_size=11 is still accepted, but state DATA drives both strobes 0.
- If no request is accepted, next state is IDLE with all mem_* outputs 0.
- In FETCH, the next edge captures mem_rdata into if_rdata and pulses if_valid.
- In DATA, the next edge pulses d_valid:
  - a load captures mem_rdata into d_rdata;
  - a store leaves d_rdata unchanged;
  - an illegal size sets d_err=1 and d_rdata=0.
- Capture of the previous access and acceptance of the next happen at the same edge, so back-to-back accesses need no bubble.
- mem_write is high for exactly one cycle per store.
- if_stall_cnt increments when if_req && !if_gnt and saturates at 0xFFFF.

## Timing
- Reset values: state IDLE. Every output is 0: gnts, valids, d_err, rdata registers, mem_*, if_stall_cnt and the starvation counter.
- Reset has priority over everything. If asserted mid-access, the in-flight access is dropped, no valid is issued, and mem_write is low from the next cycle.
- Latency: acceptance at edge E0, memory bus active during cycle E0..E1, data captured at E1. The valid pulse is high during E1..E2.
- Requesters must present the next request, or deassert req, in the cycle after acceptance. A held req is treated as a new request.
- gnt depends only on the current req inputs, the starvation counter and rst. It has no dependency on mem_rdata.
- During rst=1, both gnts are 0.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on every data grant made while if_req=1.
  - When the counter equals MAX_DATA_BURST and both requests are present, fetch wins and the counter clears.
  - The counter also clears on any fetch grant or whenever if_req=0.
- ARB_STARVE_GUARD_EN undefined: strict data priority, and the counter is not built.

## Test plan
- Reset, then if_req with if_addr=0x04 while memory returns 0x00402403 -> if_gnt=1 at E0; mem_sel=1 and mem_addr=0x04 during E0..E1; if_valid with if_rdata=0x00402403 during E1..E2.
- Store then load: d_we=1, d_size=00, d_addr=0x10, d_wdata=7, then a load from 0x10 on the next edge -> a single mem_write cycle followed by mem_read; second d_valid carries d_rdata=7; no bubble between them.
- Contention with the guard enabled and MAX_DATA_BURST=4: if_req and d_req held high for 10 cycles -> grant pattern D,D,D,D,F,D,D,D,D,F; if_stall_cnt=8.
- Same stimulus with the guard disabled -> 10 data grants; if_gnt never high; if_stall_cnt=10.
- Load with d_size=11 -> d_valid=1, d_err=1, d_rdata=0; no strobe asserted.
- rst asserted on the cycle after a store is accepted -> no d_valid; all outputs 0 from the next cycle; first grant after rst deasserts behaves as the first scenario.
